// File: rtl/dram_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dram_dump_pkg
// Description : Shared types, ASCII constants and nibble-to-hex helper for the
//               DRAM dump UART transmitter. The sequencer gains a TAIL state
//               when DRAM_DUMP_CRLF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package dram_dump_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    localparam int         ADDR_W    = 5;
    localparam logic [4:0] LAST_ADDR = 5'd31;

    // Dump sequencer: character fetch and frame hand-off to the serialiser.
    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_LOAD,
`ifdef DRAM_DUMP_CRLF_EN
        SEQ_SEND,
        SEQ_TAIL
`else
        SEQ_SEND
`endif
    } seq_state_e;

    // Serialiser phases of one 8N1 frame.
    typedef enum logic [1:0] {
        FR_IDLE,
        FR_START,
        FR_DATA,
        FR_STOP
    } frame_state_e;

    // Uppercase ASCII hex digit for a nibble.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_0 + {4'h0, nib};
        end
        return ASCII_A + {4'h0, nib} - 8'd10;
    endfunction

endpackage : dram_dump_pkg
`default_nettype wire

// File: rtl/dram_dump_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame
// Description : 8N1 serialiser. load_i in the idle state captures data_i and
//               sends START, 8 data bits LSB first and STOP, each for
//               CLKS_PER_BIT cycles. frame_done_o marks the last STOP cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame
    import dram_dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       ready_o,
    output logic       frame_done_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    frame_state_e     state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             w_baud_end;

    assign w_baud_end   = (baud_q == BAUD_LAST);
    assign ready_o      = (state_q == FR_IDLE);
    assign tx_o         = tx_q;

    // Frame state, counters and a registered (glitch-free) serial line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FR_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state: every phase change wraps the baud counter to zero.
    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        frame_done_o = 1'b0;
        case (state_q)
            FR_IDLE: begin
                if (load_i) begin
                    state_d = FR_START;
                    baud_d  = '0;
                    bit_d   = '0;
                    shift_d = data_i;
                end
            end
            FR_START: begin
                if (w_baud_end) begin
                    baud_d  = '0;
                    state_d = FR_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            FR_DATA: begin
                if (w_baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = FR_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            FR_STOP: begin
                if (w_baud_end) begin
                    baud_d       = '0;
                    state_d      = FR_IDLE;
                    frame_done_o = 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = FR_IDLE;
            end
        endcase

        case (state_d)
            FR_START: tx_d = 1'b0;
            FR_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

endmodule : uart_tx_frame
`default_nettype wire

// File: rtl/dram_dump_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : dram_dump_uart_tx
// Description : 32x4 RAM with a write port; on dump_req every nibble is sent
//               as an uppercase ASCII hex character over UART 8N1, address
//               0 first. Define DRAM_DUMP_CRLF_EN to append CR LF to a dump.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_dump_uart_tx
    import dram_dump_pkg::*;
#(
    parameter int           CLKS_PER_BIT = 868,
    parameter logic [127:0] INIT         = 128'h00F0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        wr_data,
    input  logic              dump_req,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    // Nibble a lives at ram_q[4a+3:4a]; contents come only from INIT at
    // configuration and from the write port, never from rst.
    logic [127:0]      ram_q = INIT;

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              done_q, done_d;
    logic [3:0]        w_rd_nibble;
    logic              w_load;
    logic [7:0]        w_load_data;
    logic              w_frame_ready;
    logic              w_frame_done;
`ifdef DRAM_DUMP_CRLF_EN
    logic              in_tail_q, in_tail_d;
    logic              tail_sel_q, tail_sel_d;
`endif

    // Asynchronous read: a write on the same edge is seen only afterwards.
    assign w_rd_nibble = ram_q[{rd_addr_q, 2'b00} +: 4];
    assign busy        = (state_q != SEQ_IDLE);
    assign done        = done_q;

    // Write port is live in every state, reset included.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram_q[{wr_addr, 2'b00} +: 4] <= wr_data;
        end
    end

    // Sequencer state, read address and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SEQ_IDLE;
            rd_addr_q  <= '0;
            done_q     <= 1'b0;
`ifdef DRAM_DUMP_CRLF_EN
            in_tail_q  <= 1'b0;
            tail_sel_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            done_q     <= done_d;
`ifdef DRAM_DUMP_CRLF_EN
            in_tail_q  <= in_tail_d;
            tail_sel_q <= tail_sel_d;
`endif
        end
    end

    // Next-state: fetch, hand off, and advance after each frame's STOP.
    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        done_d      = 1'b0;
        w_load      = 1'b0;
        w_load_data = nibble_to_ascii(w_rd_nibble);
`ifdef DRAM_DUMP_CRLF_EN
        in_tail_d   = in_tail_q;
        tail_sel_d  = tail_sel_q;
`endif
        case (state_q)
            SEQ_IDLE: begin
                if (dump_req) begin
                    state_d   = SEQ_LOAD;
                    rd_addr_d = '0;
                end
            end
            SEQ_LOAD: begin
                if (w_frame_ready) begin
                    w_load  = 1'b1;
                    state_d = SEQ_SEND;
                end
            end
            SEQ_SEND: begin
                if (w_frame_done) begin
`ifdef DRAM_DUMP_CRLF_EN
                    if (in_tail_q) begin
                        if (!tail_sel_q) begin
                            state_d    = SEQ_TAIL;
                            tail_sel_d = 1'b1;
                        end else begin
                            state_d    = SEQ_IDLE;
                            done_d     = 1'b1;
                            in_tail_d  = 1'b0;
                            tail_sel_d = 1'b0;
                        end
                    end else
`endif
                    if (rd_addr_q == LAST_ADDR) begin
                        rd_addr_d = '0;
`ifdef DRAM_DUMP_CRLF_EN
                        state_d    = SEQ_TAIL;
                        in_tail_d  = 1'b1;
                        tail_sel_d = 1'b0;
`else
                        state_d = SEQ_IDLE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        rd_addr_d = rd_addr_q + 5'd1;
                        state_d   = SEQ_LOAD;
                    end
                end
            end
`ifdef DRAM_DUMP_CRLF_EN
            SEQ_TAIL: begin
                w_load_data = tail_sel_q ? ASCII_LF : ASCII_CR;
                if (w_frame_ready) begin
                    w_load  = 1'b1;
                    state_d = SEQ_SEND;
                end
            end
`endif
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    uart_tx_frame #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_frame (
        .clk          (clk),
        .rst          (rst),
        .load_i       (w_load),
        .data_i       (w_load_data),
        .tx_o         (tx),
        .ready_o      (w_frame_ready),
        .frame_done_o (w_frame_done)
    );

endmodule : dram_dump_uart_tx
`default_nettype wire

// File: tb/tb_dram_dump_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_dump_uart_tx
// Description : Self-checking bench for dram_dump_uart_tx with CLKS_PER_BIT=4.
//               A UART receiver decodes tx; expected text comes from a nibble
//               array model and a hex digit string. Honours DRAM_DUMP_CRLF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dram_dump_uart_tx;

    localparam int           CPB       = 4;
    localparam logic [127:0] INIT_V    = 128'h00F0;
    localparam int           FRAME_CYC = 1 + 10 * CPB;
`ifdef DRAM_DUMP_CRLF_EN
    localparam int           N_FRAMES  = 34;
`else
    localparam int           N_FRAMES  = 32;
`endif
    localparam int           DUMP_CYC  = N_FRAMES * FRAME_CYC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       dump_req = 1'b0;
    logic       tx, busy, done;

    int n_chk  = 0;
    int n_pass = 0;
    int ferr   = 0;

    string      hexdig = "0123456789ABCDEF";
    logic [3:0] model_ram [32];
    logic [7:0] rx_q  [$];
    logic [7:0] exp_q [$];

    dram_dump_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .INIT         (INIT_V)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .dump_req (dump_req),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // UART receiver: sample mid-bit on falling edges.
    initial begin : rx_proc
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                if (tx !== 1'b0) ferr++;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                if (tx !== 1'b1) ferr++;
                rx_q.push_back(b);
            end
        end
    end

    function automatic void build_expected();
        exp_q.delete();
        for (int a = 0; a < 32; a++) exp_q.push_back(8'(hexdig[model_ram[a]]));
`ifdef DRAM_DUMP_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endfunction

    task automatic do_write(input logic [4:0] a, input logic [3:0] d, input logic with_rst);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d; rst = with_rst;
        @(negedge clk);
        wr_en = 1'b0; rst = 1'b0;
        model_ram[a] = d;
    endtask

    // One dump from a single-cycle request; optional hooks indexed by busy cycle.
    task automatic run_dump(input int rst_at, input int wr_at, input logic [4:0] wa,
                            input logic [3:0] wd, input int req_every,
                            output int bcnt, output int dcnt, output bit tmo);
        @(negedge clk);
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        bcnt = 0; dcnt = 0; tmo = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            wr_en = 1'b0; rst = 1'b0; dump_req = 1'b0;
            if (done === 1'b1) dcnt++;
            if (busy !== 1'b1) begin tmo = 1'b0; break; end
            if (bcnt == rst_at) rst = 1'b1;
            if (bcnt == wr_at) begin wr_en = 1'b1; wr_addr = wa; wr_data = wd; end
            if (req_every > 0 && (bcnt % req_every) == req_every - 1) dump_req = 1'b1;
            bcnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_chk++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_chk++; if (busy !== 1'b0 || tx !== 1'b1) $display("FAIL reset_idle: got busy=%b tx=%b expected busy=0 tx=1", busy, tx); else n_pass++;
        rx_q.delete();
    endtask

    task automatic test_default_dump();
        int b, d, extra; bit to;
        build_expected();
        rx_q.delete();
        run_dump(-1, -1, 5'd0, 4'd0, 0, b, d, to);
        extra = 0;
        repeat (6) begin @(negedge clk); if (done !== 1'b0 || busy !== 1'b0) extra++; end
        n_chk++; if (to) $display("FAIL dflt_timeout: dump never finished"); else n_pass++;
        n_chk++; if (b != DUMP_CYC) $display("FAIL dflt_busy_len: got %0d expected %0d", b, DUMP_CYC); else n_pass++;
        n_chk++; if (d != 1) $display("FAIL dflt_done_count: got %0d expected 1", d); else n_pass++;
        n_chk++; if (extra != 0) $display("FAIL dflt_after_idle: got %0d bad cycles expected 0", extra); else n_pass++;
        n_chk++; if (rx_q.size() != exp_q.size()) $display("FAIL dflt_frames: got %0d expected %0d", rx_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_chk++; if (rx_q[i] !== exp_q[i]) $display("FAIL dflt_char[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_write_dump();
        int b, d; bit to;
        for (int k = 0; k < 6; k++)
            do_write(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), 1'b0);
        do_write(5'd5, 4'hA, 1'b0);
        // A write issued while reset is held must still land.
        do_write(5'd20, 4'($urandom_range(0, 15)), 1'b1);
        repeat (2) @(negedge clk);
        build_expected();
        rx_q.delete();
        run_dump(-1, -1, 5'd0, 4'd0, 0, b, d, to);
        repeat (4) @(negedge clk);
        n_chk++; if (to || d != 1) $display("FAIL wr_done: got done=%0d timeout=%0d expected done=1 timeout=0", d, to); else n_pass++;
        n_chk++; if (rx_q.size() < 6 || rx_q[5] !== 8'h41) $display("FAIL wr_char5: got %h expected 41", (rx_q.size() > 5) ? rx_q[5] : 8'hxx); else n_pass++;
        n_chk++; if (rx_q.size() != exp_q.size()) $display("FAIL wr_frames: got %0d expected %0d", rx_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_chk++; if (rx_q[i] !== exp_q[i]) $display("FAIL wr_char[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int b, d, bad; bit to;
        // Character 3 occupies busy cycles 123..163; its DATA bits start at +5.
        run_dump(3 * FRAME_CYC + 15, -1, 5'd0, 4'd0, 0, b, d, to);
        n_chk++; if (tx !== 1'b1) $display("FAIL rstmid_tx: got %b expected 1", tx); else n_pass++;
        n_chk++; if (busy !== 1'b0 || to) $display("FAIL rstmid_busy: got %b expected 0", busy); else n_pass++;
        n_chk++; if (d != 0 || b != 3 * FRAME_CYC + 16) $display("FAIL rstmid_len: got len=%0d done=%0d expected len=%0d done=0", b, d, 3 * FRAME_CYC + 16); else n_pass++;
        bad = 0;
        repeat (60) begin @(negedge clk); if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++; end
        n_chk++; if (bad != 0) $display("FAIL rstmid_quiet: got %0d bad cycles expected 0", bad); else n_pass++;
        build_expected();
        rx_q.delete();
        run_dump(-1, -1, 5'd0, 4'd0, 0, b, d, to);
        repeat (4) @(negedge clk);
        n_chk++; if (to || d != 1 || b != DUMP_CYC) $display("FAIL rstmid_redump: got len=%0d done=%0d expected len=%0d done=1", b, d, DUMP_CYC); else n_pass++;
        n_chk++; if (rx_q.size() != exp_q.size()) $display("FAIL rstmid_frames: got %0d expected %0d", rx_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_chk++; if (rx_q[i] !== exp_q[i]) $display("FAIL rstmid_char[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_busy_ignore();
        int b, d, bad; bit to;
        build_expected();
        rx_q.delete();
        run_dump(-1, -1, 5'd0, 4'd0, 97, b, d, to);
        bad = 0;
        repeat (50) begin @(negedge clk); if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++; end
        n_chk++; if (to || b != DUMP_CYC) $display("FAIL ign_len: got %0d expected %0d", b, DUMP_CYC); else n_pass++;
        n_chk++; if (d != 1) $display("FAIL ign_done: got %0d expected 1", d); else n_pass++;
        n_chk++; if (bad != 0) $display("FAIL ign_idle: got %0d bad cycles expected 0", bad); else n_pass++;
        n_chk++; if (rx_q.size() != exp_q.size()) $display("FAIL ign_frames: got %0d expected %0d", rx_q.size(), exp_q.size()); else n_pass++;
    endtask

    task automatic test_load_edge_write();
        int b, d; bit to;
        logic [3:0] oldv, newv;
        oldv = model_ram[7];
        newv = oldv ^ 4'($urandom_range(1, 15));
        build_expected();
        rx_q.delete();
        // Busy cycle 7*41 is the LOAD cycle of address 7; the write lands on its edge.
        run_dump(-1, 7 * FRAME_CYC, 5'd7, newv, 0, b, d, to);
        repeat (4) @(negedge clk);
        n_chk++; if (to || rx_q.size() != exp_q.size()) $display("FAIL ldw_frames: got %0d expected %0d", rx_q.size(), exp_q.size()); else n_pass++;
        n_chk++; if (rx_q.size() < 8 || rx_q[7] !== 8'(hexdig[oldv])) $display("FAIL ldw_old: got %h expected %h", (rx_q.size() > 7) ? rx_q[7] : 8'hxx, 8'(hexdig[oldv])); else n_pass++;
        model_ram[7] = newv;
        build_expected();
        rx_q.delete();
        run_dump(-1, -1, 5'd0, 4'd0, 0, b, d, to);
        repeat (4) @(negedge clk);
        n_chk++; if (rx_q.size() < 8 || rx_q[7] !== 8'(hexdig[newv])) $display("FAIL ldw_new: got %h expected %h", (rx_q.size() > 7) ? rx_q[7] : 8'hxx, 8'(hexdig[newv])); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_chk++; if (rx_q[i] !== exp_q[i]) $display("FAIL ldw_char[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int phase, len1, gap, len2, dn; bit to;
        phase = 0; len1 = 0; gap = 0; len2 = 0; dn = 0; to = 1'b1;
        build_expected();
        rx_q.delete();
        @(negedge clk);
        dump_req = 1'b1;
        for (int t = 0; t < 6000; t++) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
            if (phase == 0) begin
                if (busy === 1'b1) begin phase = 1; len1 = 1; end
            end else if (phase == 1) begin
                if (busy === 1'b1) len1++; else begin phase = 2; gap = 1; end
            end else if (phase == 2) begin
                if (busy !== 1'b1) gap++; else begin phase = 3; len2 = 1; dump_req = 1'b0; end
            end else begin
                if (busy === 1'b1) len2++; else begin to = 1'b0; break; end
            end
        end
        dump_req = 1'b0;
        repeat (4) @(negedge clk);
        n_chk++; if (to) $display("FAIL b2b_timeout: phase %0d reached, expected completion", phase); else n_pass++;
        n_chk++; if (len1 != DUMP_CYC || len2 != DUMP_CYC) $display("FAIL b2b_len: got %0d/%0d expected %0d", len1, len2, DUMP_CYC); else n_pass++;
        n_chk++; if (gap != 1) $display("FAIL b2b_gap: got %0d expected 1", gap); else n_pass++;
        n_chk++; if (dn != 2) $display("FAIL b2b_done: got %0d expected 2", dn); else n_pass++;
        n_chk++; if (rx_q.size() != 2 * exp_q.size()) $display("FAIL b2b_frames: got %0d expected %0d", rx_q.size(), 2 * exp_q.size()); else n_pass++;
        for (int i = 0; i < 2 * exp_q.size() && i < rx_q.size(); i++) begin
            n_chk++; if (rx_q[i] !== exp_q[i % exp_q.size()]) $display("FAIL b2b_char[%0d]: got %h expected %h", i, rx_q[i], exp_q[i % exp_q.size()]); else n_pass++;
        end
    endtask

    task automatic test_framing();
        n_chk++; if (ferr != 0) $display("FAIL framing: got %0d errors expected 0", ferr); else n_pass++;
    endtask

    initial begin
        for (int a = 0; a < 32; a++) model_ram[a] = INIT_V[4*a +: 4];
        test_reset();
        test_default_dump();
        test_write_dump();
        test_reset_mid();
        test_busy_ignore();
        test_load_edge_write();
        test_back_to_back();
        test_framing();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_dram_dump_uart_tx
`default_nettype wire
